// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage pipelined adder/subtractor for a small custom
// float format {sign, EXP_W exponent, MAN_W fraction}.
// There are no subnormals. Rounding is round-to-nearest, ties to even.
// The flags are {invalid, overflow, underflow, inexact}.
// S1 unpacks the operands, classifies specials and aligns the significands.
// S2 forms the raw magnitude sum and its leading-zero count.
// S3 normalises, rounds and packs the result into the output register.
module fp_addsub_pipe #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_res,
    output logic [3:0]           out_flags
);

    localparam int W         = 1 + EXP_W + MAN_W;
    localparam int SIG_W     = MAN_W + 4;              // hidden, frac, G, R, S
    localparam int SUM_W     = MAN_W + 5;              // carry + SIG_W
    localparam int LZC_W     = $clog2(SUM_W);
    localparam int EXPN_W    = ((EXP_W > LZC_W) ? EXP_W : LZC_W) + 2;
    localparam int MAX_SHIFT = MAN_W + 3;

    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [MAN_W-1:0] NAN_FRAC  = MAN_W'(1) << (MAN_W - 1);
    localparam logic [W-1:0]     CANON_NAN = {1'b0, EXP_ONES, NAN_FRAC};

    // All stages move together; a full output register with no taker freezes the pipe.
    logic advance;
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance & rst_n;

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, order by magnitude, align
    // ------------------------------------------------------------------
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign a_sign = in_a[W-1];
    assign a_exp  = in_a[W-2:MAN_W];
    assign a_frac = in_a[MAN_W-1:0];
    assign b_sign = in_b[W-1] ^ in_op;                 // effective sign of B
    assign b_exp  = in_b[W-2:MAN_W];
    assign b_frac = in_b[MAN_W-1:0];

    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

    // Larger magnitude is decided on {exp, frac}; its sign is the result sign.
    logic             a_ge;
    logic             sign_l;
    logic [EXP_W-1:0] exp_l, exp_s, exp_diff;
    logic [MAN_W-1:0] frac_l, frac_s;
    logic [SIG_W-1:0] ext_s;

    assign a_ge     = (in_a[W-2:0] >= in_b[W-2:0]);
    assign sign_l   = a_ge ? a_sign : b_sign;
    assign exp_l    = a_ge ? a_exp  : b_exp;
    assign exp_s    = a_ge ? b_exp  : a_exp;
    assign frac_l   = a_ge ? a_frac : b_frac;
    assign frac_s   = a_ge ? b_frac : a_frac;
    assign exp_diff = exp_l - exp_s;
    assign ext_s    = {1'b1, frac_s, 3'b000};

    logic             c1_special;
    logic [W-1:0]     c1_spec_res;
    logic [3:0]       c1_spec_flags;
    logic             c1_sign, c1_sub, c1_sticky;
    logic [EXP_W-1:0] c1_exp;
    logic [SIG_W-1:0] c1_sig_l, c1_sig_s;
    int               shift_amt;

    // Special-case selection and right shift of the smaller significand with sticky.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        c1_special    = 1'b0;
        c1_spec_res   = '0;
        c1_spec_flags = '0;
        c1_sign       = sign_l;
        c1_sub        = a_sign ^ b_sign;
        c1_exp        = exp_l;
        c1_sig_l      = {1'b1, frac_l, 3'b000};
        c1_sig_s      = '0;
        c1_sticky     = 1'b0;
        shift_amt     = (int'(exp_diff) > MAX_SHIFT) ? MAX_SHIFT : int'(exp_diff);

        for (int i = 0; i < SIG_W; i++) begin
            if (i < shift_amt && ext_s[i]) c1_sticky = 1'b1;
        end
        c1_sig_s    = ext_s >> shift_amt;
        c1_sig_s[0] = c1_sig_s[0] | c1_sticky;

        if (a_nan || b_nan) begin
            c1_special  = 1'b1;
            c1_spec_res = CANON_NAN;
        end else if (a_inf && b_inf && (a_sign != b_sign)) begin
            c1_special    = 1'b1;
            c1_spec_res   = CANON_NAN;
            c1_spec_flags = 4'b1000;
        end else if (a_inf) begin
            c1_special  = 1'b1;
            c1_spec_res = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            c1_special  = 1'b1;
            c1_spec_res = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            c1_special  = 1'b1;
            c1_spec_res = {a_sign & b_sign, {(W-1){1'b0}}};
        end else if (a_zero) begin
            c1_special  = 1'b1;
            c1_spec_res = {b_sign, in_b[W-2:0]};
        end else if (b_zero) begin
            c1_special  = 1'b1;
            c1_spec_res = in_a;
        end
    end

    logic             s1_valid, s1_special, s1_sign, s1_sub;
    logic [W-1:0]     s1_spec_res;
    logic [3:0]       s1_spec_flags;
    logic [EXP_W-1:0] s1_exp;
    logic [SIG_W-1:0] s1_sig_l, s1_sig_s;

    // Stage 1 register: only the valid bit is reset, the payload follows it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all stages sample old values.
        if (!rst_n) begin
            // NOTE: datapath payload needs no reset; a cleared valid bit makes it don't-care.
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid      <= in_valid;
            s1_special    <= c1_special;
            s1_spec_res   <= c1_spec_res;
            s1_spec_flags <= c1_spec_flags;
            s1_sign       <= c1_sign;
            s1_sub        <= c1_sub;
            s1_exp        <= c1_exp;
            s1_sig_l      <= c1_sig_l;
            s1_sig_s      <= c1_sig_s;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude add/subtract and leading-zero count
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] c2_sum;
    logic [LZC_W-1:0] c2_lzc;

    // Larger minus smaller never goes negative, so the sum is a plain magnitude.
    always_comb begin
        c2_sum = s1_sub ? ({1'b0, s1_sig_l} - {1'b0, s1_sig_s})
                        : ({1'b0, s1_sig_l} + {1'b0, s1_sig_s});
        c2_lzc = LZC_W'(SIG_W);
        for (int i = 0; i < SIG_W; i++) begin
            if (c2_sum[i]) c2_lzc = LZC_W'(SIG_W - 1 - i);
        end
    end

    logic             s2_valid, s2_special, s2_sign;
    logic [W-1:0]     s2_spec_res;
    logic [3:0]       s2_spec_flags;
    logic [EXP_W-1:0] s2_exp;
    logic [SUM_W-1:0] s2_sum;
    logic [LZC_W-1:0] s2_lzc;

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (advance) begin
            s2_valid      <= s1_valid;
            s2_special    <= s1_special;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
            s2_sign       <= s1_sign;
            s2_exp        <= s1_exp;
            s2_sum        <= c2_sum;
            s2_lzc        <= c2_lzc;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise, round, range-check, pack
    // ------------------------------------------------------------------
    logic [SIG_W-1:0]  norm;
    logic [EXPN_W-1:0] exp_n, exp_r;
    logic [MAN_W:0]    frac_rnd;
    logic [MAN_W-1:0]  frac_r;
    logic              rnd_inc, inexact;
    logic [W-1:0]      c3_res;
    logic [3:0]        c3_flags;

    // Exponents are carried in a wider field so that underflow shows as a negative value.
    always_comb begin
        norm     = '0;
        exp_n    = '0;
        exp_r    = '0;
        frac_rnd = '0;
        frac_r   = '0;
        c3_res   = '0;
        c3_flags = '0;

        if (s2_sum[SUM_W-1]) begin
            norm    = s2_sum[SUM_W-1:1];
            norm[0] = s2_sum[1] | s2_sum[0];
            exp_n   = EXPN_W'(s2_exp) + EXPN_W'(1);
        end else begin
            norm  = s2_sum[SIG_W-1:0] << s2_lzc;
            exp_n = EXPN_W'(s2_exp) - EXPN_W'(s2_lzc);
        end

        inexact  = |norm[2:0];
        rnd_inc  = norm[2] & (norm[1] | norm[0] | norm[3]);
        frac_rnd = {1'b0, norm[SIG_W-2:3]} + (MAN_W+1)'(rnd_inc);
        frac_r   = frac_rnd[MAN_W-1:0];
        exp_r    = frac_rnd[MAN_W] ? exp_n + EXPN_W'(1) : exp_n;

        if (s2_special) begin
            c3_res   = s2_spec_res;
            c3_flags = s2_spec_flags;
        end else if (!norm[SIG_W-1]) begin
            // Exact cancellation leaves no hidden bit: always +0.
            c3_res = '0;
        end else if (exp_r[EXPN_W-1] || exp_r == '0) begin
            c3_res   = {s2_sign, {(W-1){1'b0}}};
            c3_flags = 4'b0011;
        end else if (exp_r >= EXPN_W'(EXP_ONES)) begin
            c3_res   = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            c3_flags = 4'b0101;
        end else begin
            c3_res   = {s2_sign, exp_r[EXP_W-1:0], frac_r};
            c3_flags = {3'b000, inexact};
        end
    end

    // Output register: held bit-stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_flags <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            out_res   <= c3_res;
            out_flags <= c3_flags;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (EXP_W=4, MAN_W=3, bias 7).
// The driver pushes hand-computed results when a pair is accepted.
// A monitor pops and compares whenever the DUT hands a result over.
module tb_fp_addsub_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_op;
    logic       out_valid, out_ready;
    logic [7:0] in_a, in_b, out_res;
    logic [3:0] out_flags;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flags;
        int         acc_cyc;
        bit         chk_lat;
        string      name;
    } exp_t;

    exp_t sb[$];

    fp_addsub_pipe #(.EXP_W(4), .MAN_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one pair at a negedge, hold it until accepted, and record its expected result.
    task automatic issue(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic op, input logic [7:0] er, input logic [3:0] ef,
                         input bit lat);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        #1;
        while (in_ready !== 1'b1) begin
            if (waited == 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_accept: in_ready=%b for 50 cycles, expected 1", name, in_ready);
                in_valid = 1'b0;
                return;
            end
            waited++;
            @(negedge clk);
            #1;
        end
        e.res     = er;
        e.flags   = ef;
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        e.name    = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        check({name, "_drain_left"}, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: compares each handed-over result and checks hold-stability during stalls.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_res;
    logic [3:0] prev_flags;
    exp_t       mon_e;

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_res_held", out_res, prev_res);
                check("stall_flags_held", out_flags, prev_flags);
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_res   = out_res;
            prev_flags = out_flags;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got res 0x%0h flags 0x%0h, expected none", out_res, out_flags);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_res"}, out_res, mon_e.res);
                    check({mon_e.name, "_flags"}, out_flags, mon_e.flags);
                    if (mon_e.chk_lat) check({mon_e.name, "_latency"}, cyc - mon_e.acc_cyc, 3);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: simulation still running at 200000, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_res", out_res, 0);
        check("reset_out_flags", out_flags, 0);
        check("reset_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", in_ready, 1);

        // Basic, rounding, subtract, exceptions, zeros: back-to-back stream
        issue("add_1p1",       8'h38, 8'h38, 1'b0, 8'h40, 4'b0000, 1'b1);
        issue("add_1p5",       8'h3C, 8'h3C, 1'b0, 8'h44, 4'b0000, 1'b1);
        issue("tie_even_down", 8'h38, 8'h18, 1'b0, 8'h38, 4'b0001, 1'b1);
        issue("tie_even_up",   8'h39, 8'h18, 1'b0, 8'h3A, 4'b0001, 1'b1);
        issue("sub_cancel",    8'h38, 8'h38, 1'b1, 8'h00, 4'b0000, 1'b1);
        issue("sub_2m1",       8'h40, 8'h38, 1'b1, 8'h38, 4'b0000, 1'b1);
        issue("overflow",      8'h77, 8'h77, 1'b0, 8'h78, 4'b0101, 1'b1);
        issue("inf_minus_inf", 8'h78, 8'h78, 1'b1, 8'h7C, 4'b1000, 1'b1);
        issue("nan_input",     8'h7A, 8'h38, 1'b0, 8'h7C, 4'b0000, 1'b1);
        issue("underflow",     8'h09, 8'h08, 1'b1, 8'h00, 4'b0011, 1'b1);
        issue("sub_negative",  8'h38, 8'h3C, 1'b1, 8'hB0, 4'b0000, 1'b1);
        issue("far_sticky",    8'h70, 8'h08, 1'b0, 8'h70, 4'b0001, 1'b1);
        issue("round_carry",   8'h3F, 8'h18, 1'b0, 8'h40, 4'b0001, 1'b1);
        issue("neg_zeros",     8'h80, 8'h80, 1'b0, 8'h80, 4'b0000, 1'b1);
        issue("mixed_zeros",   8'h00, 8'h80, 1'b0, 8'h00, 4'b0000, 1'b1);
        issue("x_plus_zero",   8'h3C, 8'h00, 1'b0, 8'h3C, 4'b0000, 1'b1);
        issue("zero_minus_x",  8'h00, 8'h38, 1'b1, 8'hB8, 4'b0000, 1'b1);
        issue("zero_frac_ign", 8'h05, 8'h38, 1'b0, 8'h38, 4'b0000, 1'b1);
        issue("ninf_plus_fin", 8'hF8, 8'h48, 1'b0, 8'hF8, 4'b0000, 1'b1);
        issue("inf_minus_ninf",8'h78, 8'hF8, 1'b1, 8'h78, 4'b0000, 1'b1);
        drain("stream");

        // Back-pressure: 5 ops streamed, out_ready held low for 4 edges
        fork
            begin
                issue("bp1", 8'h38, 8'h38, 1'b0, 8'h40, 4'b0000, 1'b0);
                issue("bp2", 8'h3C, 8'h3C, 1'b0, 8'h44, 4'b0000, 1'b0);
                issue("bp3", 8'h40, 8'h38, 1'b1, 8'h38, 4'b0000, 1'b0);
                issue("bp4", 8'h39, 8'h18, 1'b0, 8'h3A, 4'b0001, 1'b0);
                issue("bp5", 8'h77, 8'h77, 1'b0, 8'h78, 4'b0101, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) begin
                    #1;
                    check("bp_in_ready_low", in_ready, 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain("backpressure");

        // Reset with two operations in flight
        issue("rst_op1", 8'h38, 8'h38, 1'b0, 8'h40, 4'b0000, 1'b0);
        issue("rst_op2", 8'h3C, 8'h3C, 1'b0, 8'h44, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_res", out_res, 0);
        check("midrst_out_flags", out_flags, 0);
        check("midrst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            check("post_rst_no_stale", out_valid, 0);
        end
        issue("post_rst_op", 8'h39, 8'h18, 1'b0, 8'h3A, 4'b0001, 1'b1);
        drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
